// File: rtl/reg_bank_32x32.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_32x32
// Purpose  : 32 x 32-bit register file with two async read ports, one sync
//            write port and an EXT register that holds the upper result word.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_32x32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  wrAddr,
    input  logic [31:0] wrData,
    input  logic [31:0] wrDataExt,
    input  logic [4:0]  rdAddrA,
    output logic [31:0] rdDataA,
    input  logic [4:0]  rdAddrB,
    output logic [31:0] rdDataB,
    output logic [31:0] rout
);

    localparam int          C_NUM_REGS = 32;
    localparam logic [4:0]  C_ZERO_IDX = 5'd0;
    localparam logic [31:0] C_ZERO     = 32'h0000_0000;

    logic [31:0] regs_q [C_NUM_REGS];
    logic [31:0] ext_q;
    logic [31:0] ext_d;
    logic        reg_we_d;

    assign reg_we_d = RegWrite && (wrAddr != C_ZERO_IDX);
    assign ext_d    = RegWrite ? wrDataExt : ext_q;

    // Index 0 is never written, so it holds the reset value of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_q[i] <= C_ZERO;
            end
        end else if (reg_we_d) begin
            regs_q[wrAddr] <= wrData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_q <= C_ZERO;
        end else begin
            ext_q <= ext_d;
        end
    end

    // Reads force zero for index 0 and while reset is held.
    always_comb begin
        rdDataA = C_ZERO;
        rdDataB = C_ZERO;
        rout    = C_ZERO;
        if (!reset) begin
            if (rdAddrA != C_ZERO_IDX) rdDataA = regs_q[rdAddrA];
            if (rdAddrB != C_ZERO_IDX) rdDataB = regs_q[rdAddrB];
            rout = ext_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_32x32.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_32x32
// Purpose  : Directed self-checking bench for reg_bank_32x32 with a queue
//            of expected values consumed as outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_32x32;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic [31:0] wrDataExt;
    logic [4:0]  rdAddrA;
    logic [31:0] rdDataA;
    logic [4:0]  rdAddrB;
    logic [31:0] rdDataB;
    logic [31:0] rout;

    int          n_checks;
    int          n_fail;
    string       tag_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] model [32];
    logic [31:0] model_ext;

    reg_bank_32x32 dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .wrAddr    (wrAddr),
        .wrData    (wrData),
        .wrDataExt (wrDataExt),
        .rdAddrA   (rdAddrA),
        .rdDataA   (rdDataA),
        .rdAddrB   (rdAddrB),
        .rdDataB   (rdDataB),
        .rout      (rout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] expv;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            tag  = tag_q.pop_front();
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
            end
        end
    endtask

    // Drives one enabled write at a negedge; the model updates at the edge.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] e);
        @(negedge clk);
        RegWrite  = 1'b1;
        wrAddr    = a;
        wrData    = d;
        wrDataExt = e;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        if (a != 5'd0) model[a] = d;
        model_ext = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        RegWrite  = 1'b0;
        wrAddr    = '0;
        wrData    = '0;
        wrDataExt = '0;
        rdAddrA   = 5'd3;
        rdAddrB   = 5'd31;
        for (int i = 0; i < 32; i++) model[i] = '0;
        model_ext = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        push("reset_rdA", 32'h0); push("reset_rdB", 32'h0); push("reset_rout", 32'h0);
        check(rdDataA); check(rdDataB); check(rout);
        @(negedge clk);
        reset = 1'b0;

        // Basic write/read
        do_write(5'd10, 32'h15, 32'h4D);
        rdAddrA = 5'd15;
        rdAddrB = 5'd10;
        #1;
        push("basic_rdA", 32'h0); push("basic_rdB", 32'h15); push("basic_rout", 32'h4D);
        check(rdDataA); check(rdDataB); check(rout);

        // Second write: no bypass before the edge
        @(negedge clk);
        RegWrite  = 1'b1;
        wrAddr    = 5'd15;
        wrData    = 32'h03;
        wrDataExt = 32'h69;
        #1;
        push("second_pre_rdA", 32'h0); push("second_pre_rout", 32'h4D);
        check(rdDataA); check(rout);
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        model[15] = 32'h03;
        model_ext = 32'h69;
        push("second_rdA", 32'h03); push("second_rdB", 32'h15); push("second_rout", 32'h69);
        check(rdDataA); check(rdDataB); check(rout);

        // Register 0 discards data but EXT still updates
        do_write(5'd0, 32'hFFFF_FFFF, 32'h12);
        rdAddrA = 5'd0;
        rdAddrB = 5'd0;
        #1;
        push("r0_rdA", 32'h0); push("r0_rdB", 32'h0); push("r0_rout", 32'h12);
        check(rdDataA); check(rdDataB); check(rout);

        // Write disabled across several edges
        @(negedge clk);
        RegWrite  = 1'b0;
        wrAddr    = 5'd10;
        wrData    = 32'hDEAD;
        wrDataExt = 32'hBEEF;
        rdAddrB   = 5'd10;
        repeat (3) @(posedge clk);
        #1;
        push("nowr_rdB", 32'h15); push("nowr_rout", 32'h12);
        check(rdDataB); check(rout);

        // Reset mid-cycle with a pending write, no clock edge needed
        rdAddrA   = 5'd15;
        rdAddrB   = 5'd10;
        RegWrite  = 1'b1;
        wrAddr    = 5'd20;
        wrData    = 32'hCAFE_F00D;
        wrDataExt = 32'h7777_7777;
        @(posedge clk);
        #1;
        model[20] = 32'hCAFE_F00D;
        model_ext = 32'h7777_7777;
        #2;
        reset = 1'b1;
        #1;
        push("rst_async_rdA", 32'h0); push("rst_async_rdB", 32'h0); push("rst_async_rout", 32'h0);
        check(rdDataA); check(rdDataB); check(rout);
        @(posedge clk);
        #1;
        push("rst_held_rout", 32'h0);
        check(rout);
        @(negedge clk);
        RegWrite = 1'b0;
        reset    = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        model_ext = '0;
        rdAddrA = 5'd20;
        #1;
        push("post_rst_rdA20", 32'h0); push("post_rst_rdB10", 32'h0); push("post_rst_rout", 32'h0);
        check(rdDataA); check(rdDataB); check(rout);

        // Full sweep
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'h0101_0101 * 32'(i), 32'hA5A5_0000 | 32'(i));
        end
        for (int i = 0; i < 32; i++) begin
            rdAddrA = 5'(i);
            rdAddrB = 5'(31 - i);
            #1;
            push($sformatf("sweep_rdA_%0d", i), (i == 0) ? 32'h0 : 32'h0101_0101 * 32'(i));
            check(rdDataA);
            push($sformatf("sweep_rdB_%0d", 31 - i), model[31 - i]);
            check(rdDataB);
        end
        push("sweep_rout", 32'hA5A5_001F);
        check(rout);
        push("sweep_model_ext", model_ext);
        check(rout);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
